ifetch_guard_mp: RTL and testbench

IFETCH_GUARD_MP -- requirements
Module: ifetch_guard_mp

---
 rtl/ifetch_guard_mp.sv | 137 +++++++++++++
 tb/tb_ifetch_guard_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_guard_mp.sv
// Instruction-fetch execute-permission guard for NPORTS fetch channels.
// Denied fetches are blocked, counted, and the first one is reported to the trap unit.
module ifetch_guard_mp #(
    parameter int         NPORTS     = 2,
    parameter int         ADDR_W     = 32,
    parameter logic [4:0] CAUSE_CODE = 5'hA,
    parameter int         CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        if_req_i,
    input  logic [NPORTS*ADDR_W-1:0] if_addr_i,
    input  logic [NPORTS-1:0]        mpu_exec_allow_i,
    output logic [NPORTS-1:0]        if_req_o,
    input  logic [NPORTS-1:0]        ic_miss_i,
    output logic [NPORTS-1:0]        block_refill_o,
    output logic                     fault_valid_o,
    input  logic                     fault_ack_i,
    output logic [31:0]              fault_cause_o,
    output logic [ADDR_W-1:0]        fault_tval_o,
    output logic [2:0]               fault_port_o,
    output logic [CNT_W-1:0]         deny_cnt_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int SUM_W = CNT_W + 4;

    state_t              state_q, state_d;
    logic                fault_valid_q, fault_valid_d;
    logic [ADDR_W-1:0]   fault_tval_q, fault_tval_d;
    logic [2:0]          fault_port_q, fault_port_d;
    logic [CNT_W-1:0]    deny_cnt_q, deny_cnt_d;

    logic [NPORTS-1:0]   denied;
    logic [2:0]          sel_port;
    logic [ADDR_W-1:0]   sel_addr;
    logic                in_run;

    function automatic logic [3:0] popcount(input logic [NPORTS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NPORTS; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // A sum crossing the top of the counter range clamps instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [3:0] p);
        logic [SUM_W-1:0] s;
        logic [CNT_W-1:0] mx;
        mx = '1;
        s  = SUM_W'(c) + SUM_W'(p);
        if (s > SUM_W'(mx)) begin
            return mx;
        end
        return s[CNT_W-1:0];
    endfunction

    assign in_run = (state_q == RUN);
    assign denied = if_req_i & ~mpu_exec_allow_i;

    always_comb begin
        sel_port = '0;
        sel_addr = '0;
        // Scan downward so the lowest-index denial wins.
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (denied[k]) begin
                sel_port = 3'(k);
                sel_addr = if_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        fault_valid_d = fault_valid_q;
        fault_tval_d  = fault_tval_q;
        fault_port_d  = fault_port_q;
        deny_cnt_d    = sat_add(deny_cnt_q, popcount(denied));
        case (state_q)
            RUN: begin
                if (|denied) begin
                    state_d       = HOLD;
                    fault_valid_d = 1'b1;
                    fault_tval_d  = sel_addr;
                    fault_port_d  = sel_port;
                end
            end
            HOLD: begin
                if (fault_ack_i) begin
                    state_d       = RECOVER;
                    fault_valid_d = 1'b0;
                end
            end
            RECOVER: begin
                state_d = RUN;
            end
            default: begin
                state_d       = RUN;
                fault_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fault_valid_q <= 1'b0;
            fault_tval_q  <= '0;
            fault_port_q  <= '0;
            deny_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fault_valid_q <= fault_valid_d;
            fault_tval_q  <= fault_tval_d;
            fault_port_q  <= fault_port_d;
            deny_cnt_q    <= deny_cnt_d;
        end
    end

    assign if_req_o       = in_run ? (if_req_i & mpu_exec_allow_i) : '0;
    assign block_refill_o = ic_miss_i & (~mpu_exec_allow_i | {NPORTS{~in_run}});
    assign fault_valid_o  = fault_valid_q;
    assign fault_cause_o  = {27'b0, CAUSE_CODE};
    assign fault_tval_o   = fault_tval_q;
    assign fault_port_o   = fault_port_q;
    assign deny_cnt_o     = deny_cnt_q;
    assign busy_o         = ~in_run;

endmodule

// File: tb/tb_ifetch_guard_mp.sv
// Randomized bench for ifetch_guard_mp against a transaction-level fault/counter model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_ifetch_guard_mp;

    localparam int NP = 2;
    localparam int AW = 32;

    logic           clk;
    logic           rst_n;
    logic [NP-1:0]  if_req_i;
    logic [NP*AW-1:0] if_addr_i;
    logic [NP-1:0]  mpu_exec_allow_i;
    logic [NP-1:0]  ic_miss_i;
    logic           fault_ack_i;

    logic [NP-1:0]  if_req_o, block_refill_o;
    logic           fault_valid_o, busy_o;
    logic [31:0]    fault_cause_o;
    logic [AW-1:0]  fault_tval_o;
    logic [2:0]     fault_port_o;
    logic [15:0]    deny_cnt_o;

    logic [NP-1:0]  s_if_req_o, s_block_refill_o;
    logic           s_fault_valid_o, s_busy_o;
    logic [31:0]    s_fault_cause_o;
    logic [AW-1:0]  s_fault_tval_o;
    logic [2:0]     s_fault_port_o;
    logic [1:0]     s_deny_cnt_o;

    ifetch_guard_mp #(.NPORTS(NP), .ADDR_W(AW), .CAUSE_CODE(5'hA), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .mpu_exec_allow_i(mpu_exec_allow_i), .if_req_o(if_req_o), .ic_miss_i(ic_miss_i),
        .block_refill_o(block_refill_o), .fault_valid_o(fault_valid_o), .fault_ack_i(fault_ack_i),
        .fault_cause_o(fault_cause_o), .fault_tval_o(fault_tval_o), .fault_port_o(fault_port_o),
        .deny_cnt_o(deny_cnt_o), .busy_o(busy_o)
    );

    ifetch_guard_mp #(.NPORTS(NP), .ADDR_W(AW), .CAUSE_CODE(5'hA), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .mpu_exec_allow_i(mpu_exec_allow_i), .if_req_o(s_if_req_o), .ic_miss_i(ic_miss_i),
        .block_refill_o(s_block_refill_o), .fault_valid_o(s_fault_valid_o), .fault_ack_i(fault_ack_i),
        .fault_cause_o(s_fault_cause_o), .fault_tval_o(s_fault_tval_o), .fault_port_o(s_fault_port_o),
        .deny_cnt_o(s_deny_cnt_o), .busy_o(s_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pending report, a one-cycle recovery window, last capture, raw denial total.
    bit          m_pending;
    bit          m_recover;
    logic [AW-1:0] m_tval;
    int          m_port;
    longint      m_total;

    function automatic longint clamp(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_recover = 0;
        m_tval    = '0;
        m_port    = 0;
        m_total   = 0;
    endtask

    task automatic check_outputs();
        bit            running;
        logic [NP-1:0] exp_req, exp_blk;
        running = !m_pending && !m_recover;
        exp_req = running ? (if_req_i & mpu_exec_allow_i) : '0;
        exp_blk = '0;
        for (int k = 0; k < NP; k++) begin
            exp_blk[k] = ic_miss_i[k] && (!mpu_exec_allow_i[k] || !running);
        end
        check("if_req_o",     64'(if_req_o), 64'(exp_req));
        check("block_refill", 64'(block_refill_o), 64'(exp_blk));
        check("fault_valid",  64'(fault_valid_o), 64'(m_pending));
        check("busy",         64'(busy_o), 64'(!running));
        check("cause",        64'(fault_cause_o), 64'h0A);
        check("tval",         64'(fault_tval_o), 64'(m_tval));
        check("port",         64'(fault_port_o), 64'(m_port));
        check("deny_cnt",     64'(deny_cnt_o), 64'(clamp(m_total, 65535)));
        check("deny_cnt_sat", 64'(s_deny_cnt_o), 64'(clamp(m_total, 3)));
    endtask

    task automatic model_clock();
        int ndenied;
        int first;
        ndenied = 0;
        first   = -1;
        for (int k = 0; k < NP; k++) begin
            if (if_req_i[k] && !mpu_exec_allow_i[k]) begin
                ndenied++;
                if (first < 0) first = k;
            end
        end
        m_total += ndenied;
        if (m_pending) begin
            if (fault_ack_i) begin
                m_pending = 0;
                m_recover = 1;
            end
        end else if (m_recover) begin
            m_recover = 0;
        end else if (first >= 0) begin
            m_pending = 1;
            m_port    = first;
            m_tval    = if_addr_i[first*AW +: AW];
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and checked mid-cycle.
    task automatic step(input logic [NP-1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [NP-1:0] allow, input logic [NP-1:0] miss, input logic ack);
        if_req_i         = req;
        if_addr_i        = {a1, a0};
        mpu_exec_allow_i = allow;
        ic_miss_i        = miss;
        fault_ack_i      = ack;
        #4;
        check_outputs();
        if (rst_n) model_clock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        if_req_i = '0; if_addr_i = '0; mpu_exec_allow_i = '0; ic_miss_i = '0; fault_ack_i = 1'b0;
        @(posedge clk); #1;
        // RUN equations must hold while reset is asserted.
        step(2'b11, 32'h10, 32'h20, 2'b01, 2'b11, 1'b1);
        step(2'b01, 32'h1000, 32'h0, 2'b01, 2'b00, 1'b0);
        rst_n = 1'b1;

        step(2'b01, 32'h1000, 32'h0, 2'b01, 2'b00, 1'b0);
        step(2'b10, 32'h0, 32'h8000_0040, 2'b01, 2'b10, 1'b0);
        step(2'b01, 32'h2000, 32'h0, 2'b00, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 2'b01, 1'b1);
        step(2'b01, 32'h3000, 32'h0, 2'b01, 2'b00, 1'b1);
        step(2'b01, 32'h3000, 32'h0, 2'b01, 2'b00, 1'b0);
        step(2'b11, 32'h100, 32'h200, 2'b00, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 1'b1);
        step(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 1'b0);

        // Five isolated denials, each acknowledged, drive the 2-bit counter into saturation.
        rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 32'h4000 + 32'(i), 32'h0, 2'b10, 2'b00, 1'b0);
            step(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 1'b1);
            step(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [NP-1:0] req, allow, miss;
            req   = NP'($urandom);
            miss  = NP'($urandom);
            allow = '0;
            for (int k = 0; k < NP; k++) allow[k] = ($urandom_range(0, 9) < 7);
            step(req, $urandom, $urandom, allow, miss, ($urandom_range(0, 9) < 3));
        end

        // Reset dropped mid-cycle while a fault is held.
        step(2'b10, 32'h0, 32'h8000_0040, 2'b00, 2'b00, 1'b0);
        if (!m_pending) step(2'b01, 32'h5000, 32'h0, 2'b00, 2'b00, 1'b0);
        check("hold_before_rst", 64'(fault_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_fault_valid", 64'(fault_valid_o), 64'd0);
        check("rst_busy",        64'(busy_o), 64'd0);
        check("rst_cnt",         64'(deny_cnt_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2'b01, 32'h1000, 32'h0, 2'b11, 2'b00, 1'b0);
        step(2'b11, 32'h1004, 32'h2004, 2'b11, 2'b11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
